// File: rtl/wb_commit_arbiter_pkg.sv
// Shared widths and the commit-source select for the writeback commit unit.
package wb_pkg;

    localparam int WB_XLEN     = 32;
    localparam int WB_AW       = 5;
    localparam int WB_NUM_REGS = 2 ** WB_AW;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_HOLD,
        SRC_LD
    } wb_src_e;

endpackage

// File: rtl/wb_commit_arbiter_tag_fifo.sv
// Destination-register tag FIFO for outstanding loads, in issue order.
module wb_tag_fifo #(
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [AW-1:0] i_din,
    input  logic          i_pop,
    output logic [AW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage needs no reset; it is only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_commit_arbiter.sv
// Merges ALU results and in-order load returns onto the register file write
// port, with a one-entry hold buffer and a load-use busy scoreboard.
module wb_commit_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN     = WB_XLEN,
    parameter int AW       = WB_AW,
    parameter int LQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [AW-1:0]     alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_issue,
    input  logic [AW-1:0]     ld_issue_rd,
    output logic              ld_issue_ready,
    input  logic              ld_valid,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,
    output logic [2**AW-1:0]  busy,
    output logic              rg_wrt_en,
    output logic [AW-1:0]     rg_wrt_addr,
    output logic [XLEN-1:0]   rg_wrt_data,
    output logic              proto_err
);

    localparam int NR = 2 ** AW;

    logic            r_hold_valid;
    logic [AW-1:0]   r_hold_rd;
    logic [XLEN-1:0] r_hold_data;
    logic [NR-1:0]   r_busy;
    logic            r_wrt_en;
    logic [AW-1:0]   r_wrt_addr;
    logic [XLEN-1:0] r_wrt_data;
    logic            r_err;

    logic [AW-1:0]   w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_ld_acc;
    logic            w_capture;
    wb_src_e         w_src;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_data;
    logic            w_wr;
    logic [NR-1:0]   w_busy_nxt;

    wb_tag_fifo #(
        .AW    (AW),
        .DEPTH (LQ_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (ld_issue_rd),
        .i_pop   (w_ld_acc),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign ld_ready       = !r_hold_valid;
    assign ld_issue_ready = !w_full && !r_busy[ld_issue_rd];
    assign w_push         = ld_issue && ld_issue_ready;
    // A return with no tag outstanding is dropped, not popped.
    assign w_ld_acc       = ld_valid && ld_ready && !w_empty;
    assign w_capture      = alu_valid && w_ld_acc;

    always_comb begin
        w_src = SRC_NONE;
        if (alu_valid)         w_src = SRC_ALU;
        else if (r_hold_valid) w_src = SRC_HOLD;
        else if (w_ld_acc)     w_src = SRC_LD;
    end

    always_comb begin
        w_rd   = '0;
        w_data = '0;
        unique case (w_src)
            SRC_ALU: begin
                w_rd   = alu_rd;
                w_data = alu_data;
            end
            SRC_HOLD: begin
                w_rd   = r_hold_rd;
                w_data = r_hold_data;
            end
            SRC_LD: begin
                w_rd   = w_head;
                w_data = ld_data;
            end
            default: ;
        endcase
    end

    assign w_wr = (w_src != SRC_NONE) && (w_rd != '0);

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_src == SRC_HOLD)    w_busy_nxt[r_hold_rd] = 1'b0;
        else if (w_src == SRC_LD) w_busy_nxt[w_head]    = 1'b0;
        if (w_push) w_busy_nxt[ld_issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_rd    <= '0;
            r_hold_data  <= '0;
            r_busy       <= '0;
            r_wrt_en     <= 1'b0;
            r_wrt_addr   <= '0;
            r_wrt_data   <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_capture) begin
                r_hold_valid <= 1'b1;
                r_hold_rd    <= w_head;
                r_hold_data  <= ld_data;
            end else if (w_src == SRC_HOLD) begin
                r_hold_valid <= 1'b0;
            end
            r_busy   <= w_busy_nxt;
            r_wrt_en <= w_wr;
            if (w_wr) begin
                r_wrt_addr <= w_rd;
                r_wrt_data <= w_data;
            end
            r_err <= r_err
                   | (ld_valid && w_empty)
                   | (alu_valid && r_busy[alu_rd]);
        end
    end

    assign busy        = r_busy;
    assign rg_wrt_en   = r_wrt_en;
    assign rg_wrt_addr = r_wrt_addr;
    assign rg_wrt_data = r_wrt_data;
    assign proto_err   = r_err;

endmodule

// File: doc/wb_commit_arbiter.md
# wb_commit_arbiter

Writeback commit unit that drives the register file write port (write enable, address, data) for the single-issue RISC-V core. It merges two producers onto the one write port: single-cycle ALU results and in-order load returns from the data memory. It records the destination of each outstanding load in a tag FIFO and keeps a per-register busy scoreboard so decode can stall on load-use hazards. It buffers a load return that collides with an ALU write, and never commits a write to x0.

## Interface

- XLEN, 32, datapath width
- AW, 5, register address width (NUM_REGS = 2**AW)
- LQ_DEPTH, 4, maximum outstanding loads (power of two, ≥2)

Clock/reset: reset reset, asynchronous, active-high; clock clk.

- clk  in  1  clock
- reset  in  1  async active-high reset
- alu_valid  in  1  ALU result present this cycle (cannot be stalled)
- alu_rd  in  AW  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_issue  in  1  load issued to memory this cycle
- ld_issue_rd  in  AW  destination of issued load
- ld_issue_ready  out  1  issue may be accepted (combinational)
- ld_valid  in  1  load data returning (in issue order)
- ld_data  in  XLEN  returned load data
- ld_ready  out  1  return accepted (combinational)
- busy  out  NUM_REGS  bit r set while a load to r is outstanding
- rg_wrt_en  out  1  register file write enable (registered)
- rg_wrt_addr  out  AW  register file write address (registered)
- rg_wrt_data  out  XLEN  register file write data (registered)
- proto_err  out  1  sticky protocol-violation flag

## Operation

- Issue: accepted when ld_issue && ld_issue_ready.
  - ld_issue_ready = !tag_full && !busy[ld_issue_rd].
  - Accepted issue pushes ld_issue_rd to the tag FIFO.
  - Sets busy[rd] unless rd==0.
- Return: accepted when ld_valid && ld_ready; ld_ready = !hold_valid.
  - Pops the FIFO head; head gives the destination rd.
- Commit priority per cycle: ALU > hold register > direct load return.
  - ALU wins with hold empty and a load return accepted: load {rd, data} captured into the hold register.
  - Hold valid and no ALU: hold commits, hold_valid clears.
- Busy clear:
  - busy[rd] clears in the cycle the load's write is launched (rg_wrt_en rises next edge).
  - Set and clear of different registers in the same cycle are both applied.
- x0: a winner with rd==0 still consumes its slot (FIFO pop, hold clear); rg_wrt_en stays 0.
- proto_err set (sticky until reset) on any of:
  - ld_valid with the FIFO empty;
  - alu_valid with busy[alu_rd] (WAW against a pending load).
  - The offending load return is dropped. The ALU write still commits.
- Reset mid-operation discards all outstanding tags, the hold entry, and busy bits.

## Timing

- Reset values: rg_wrt_en=0, rg_wrt_addr=0, rg_wrt_data=0, busy=0, proto_err=0; FIFO empty; hold_valid=0; ld_issue_ready=1; ld_ready=1.
- ALU latency: alu_valid at edge N → rg_wrt_en/addr/data valid after edge N+1, for one cycle.
- Direct load latency: same 1 cycle.
- Collided load: commits 1 cycle after the first cycle with no ALU write; minimum latency 2.
- ld_ready is low during every cycle hold_valid=1, including the cycle the hold drains.
- FIFO full plus a same-cycle pop: issue is still refused (conservative, full-only check).
- Pointers wrap modulo LQ_DEPTH. Count width is log2(LQ_DEPTH)+1.
- Same-cycle issue and commit to the same rd: issue is refused because busy is still set.

## Structure

- Package wb_pkg holds:
  - XLEN and AW defaults;
  - NUM_REGS;
  - wb_src_e enum {SRC_NONE, SRC_ALU, SRC_HOLD, SRC_LD} for the commit mux select.
- Sub-module wb_tag_fifo: synchronous FIFO of AW-bit tags, depth LQ_DEPTH, ports push/pop/head/full/empty, async reset. The top instantiates it once.
- The top level holds the hold register, scoreboard, priority mux, output registers and proto_err.

## Test plan

- Reset, then alu_valid rd=5 data=0x1234 → next cycle rg_wrt_en=1, addr=5, data=0x1234; all outputs 0 during reset.
- Issue loads rd=3 and rd=7 → busy[3], busy[7] = 1.
  - Return 0xAA then 0xBB → writes (3,0xAA) then (7,0xBB); busy bits clear; issue rd=3 again is accepted.
- Load return 0xCC for rd=9 in the same cycle as ALU rd=4 data=0x11:
  - write (4,0x11), then (9,0xCC) next cycle;
  - ld_ready=0 for one cycle.
- Issue 4 loads → ld_issue_ready=0 on the 5th; one return → ld_issue_ready=1 the following cycle.
- Errors and x0:
  - ld_valid with the FIFO empty → proto_err=1 and stays set; no write.
  - Load to x0 issued and returned → no write; busy stays 0.
- Issue 2 loads, assert reset mid-flight → busy=0, FIFO empty; a later ld_valid sets proto_err.
